// File: rtl/mycpu_soc.sv
// mycpu_soc: single-cycle RV32I SoC, core + writable ROM + RAM on a fixed decoder (ports: clk, rst, uart_debug_pin)
module mycpu_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];
  assign rd1 = ra1 == 5'd0 ? 32'd0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? 32'd0 : regs[ra2];
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0)
      regs[wa] <= wd;
endmodule

module mycpu_rom #(
  parameter int WORDS = 4096,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] iidx,
  input  logic [AW-1:0] didx,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  output logic [31:0]   instr,
  output logic [31:0]   rdata
);
  logic [31:0] _rom [0:WORDS-1];
  assign instr = _rom[iidx];
  assign rdata = _rom[didx];
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) _rom[didx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

module mycpu_ram #(
  parameter int WORDS = 4096,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] _ram [0:WORDS-1];
  assign rdata = _ram[idx];
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) _ram[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

module mycpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] daddr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata
);
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67;
  localparam logic [6:0] BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, r1, r2, b, alu, ld, wd, npc;
  logic [4:0]  sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  strb;
  logic        eq, lt, ltu, taken, we;
  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  mycpu_regs u_regs (
    .clk(clk), .rst(rst), .ra1(instr[19:15]), .ra2(instr[24:20]), .wa(instr[11:7]),
    .we(we), .wd(wd), .rd1(r1), .rd2(r2)
  );
  assign b  = op == OP ? r2 : imm_i;
  assign sh = b[4:0];
  always_comb begin
    alu = '0;
    case (f3)
      3'd0: alu = (op == OP && instr[30]) ? r1 - b : r1 + b;
      3'd1: alu = r1 << sh;
      3'd2: alu = {31'd0, $signed(r1) < $signed(b)};
      3'd3: alu = {31'd0, r1 < b};
      3'd4: alu = r1 ^ b;
      3'd5: alu = instr[30] ? $unsigned($signed(r1) >>> sh) : r1 >> sh;
      3'd6: alu = r1 | b;
      3'd7: alu = r1 & b;
    endcase
  end
  assign eq    = r1 == r2;
  assign lt    = $signed(r1) < $signed(r2);
  assign ltu   = r1 < r2;
  assign taken = f3 == 3'd0 ? eq : f3 == 3'd1 ? !eq : f3 == 3'd4 ? lt :
                 f3 == 3'd5 ? !lt : f3 == 3'd6 ? ltu : f3 == 3'd7 ? !ltu : 1'b0;
  assign daddr   = r1 + (op == STORE ? imm_s : imm_i);
  assign ld_byte = rdata[{daddr[1:0], 3'b000} +: 8];
  assign ld_half = daddr[1] ? rdata[31:16] : rdata[15:0];
  assign ld = f3 == 3'd0 ? {{24{ld_byte[7]}}, ld_byte} : f3 == 3'd1 ? {{16{ld_half[15]}}, ld_half} :
              f3 == 3'd4 ? {24'd0, ld_byte} : f3 == 3'd5 ? {16'd0, ld_half} : rdata;
  assign strb  = f3 == 3'd0 ? 4'b0001 << daddr[1:0] : f3 == 3'd1 ? (daddr[1] ? 4'b1100 : 4'b0011) :
                 f3 == 3'd2 ? 4'b1111 : 4'b0000;
  // reset suppresses the store so an aborted instruction leaves memory untouched
  assign wstrb = (rst || op != STORE) ? 4'b0000 : strb;
  assign wdata = f3 == 3'd0 ? {4{r2[7:0]}} : f3 == 3'd1 ? {2{r2[15:0]}} : r2;
  assign we = op == LUI || op == AUIPC || op == JAL || op == JALR || op == OP || op == OPIMM || op == LOAD;
  assign wd = op == LUI ? imm_u : op == AUIPC ? pc + imm_u : (op == JAL || op == JALR) ? pc + 32'd4 :
              op == LOAD ? ld : alu;
  assign npc = op == JAL ? pc + imm_j : op == JALR ? (r1 + imm_i) & ~32'd1 :
               (op == BRANCH && taken) ? pc + imm_b : pc + 32'd4;
  always_ff @(posedge clk)
    pc <= rst ? RESET_PC : npc;
endmodule

module mycpu_soc #(
  parameter int          ROM_WORDS = 4096,
  parameter int          RAM_WORDS = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  input logic uart_debug_pin
);
  localparam int RA = $clog2(ROM_WORDS);
  localparam int RR = $clog2(RAM_WORDS);
  logic [31:0] iaddr, instr, daddr, wdata, rdata, rom_rdata, ram_rdata;
  logic [3:0]  wstrb;
  logic        sel_rom, sel_ram, unused;
  assign sel_rom = daddr[31:28] == 4'h0;
  assign sel_ram = daddr[31:28] == 4'h1;
  assign rdata   = sel_rom ? rom_rdata : sel_ram ? ram_rdata : 32'd0;
  assign unused  = ^{uart_debug_pin, iaddr, daddr};
  mycpu_core #(.RESET_PC(RESET_PC)) u_MyCPU (
    .clk(clk), .rst(rst), .pc(iaddr), .instr(instr),
    .daddr(daddr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata)
  );
  mycpu_rom #(.WORDS(ROM_WORDS)) u_rom (
    .clk(clk), .iidx(iaddr[RA+1:2]), .didx(daddr[RA+1:2]),
    .wstrb(sel_rom ? wstrb : 4'b0000), .wdata(wdata), .instr(instr), .rdata(rom_rdata)
  );
  mycpu_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clk(clk), .idx(daddr[RR+1:2]),
    .wstrb(sel_ram ? wstrb : 4'b0000), .wdata(wdata), .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_mycpu_soc.sv
// tb_mycpu_soc: directed-program bench for mycpu_soc
module tb_mycpu_soc;
  logic clk = 0, rst = 1, uart_debug_pin = 0;
  int total = 0, passed = 0;
  mycpu_soc dut (.clk(clk), .rst(rst), .uart_debug_pin(uart_debug_pin));
  always #5 clk = ~clk;

  task automatic put(input int i, input logic [31:0] w);
    dut.u_rom._rom[i] = w;
  endtask

  task automatic hold_and_clear();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 64; i++) dut.u_rom._rom[i] = 32'h0000_0013;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_and_alu();
    logic [31:0] exp [0:3];
    hold_and_clear();
    put(0, 32'hFFF00093);
    put(1, 32'h00103133);
    put(2, 32'h4040D193);
    put(3, 32'h00108033);
    release_rst();
    total++;
    if (dut.u_MyCPU.pc !== 32'd0) $display("FAIL reset_pc: got %h want %h", dut.u_MyCPU.pc, 32'd0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut.u_MyCPU.u_regs.regs[i] !== 32'd0) $display("FAIL reset_x%0d: got %h want 0", i, dut.u_MyCPU.u_regs.regs[i]);
      else passed++;
    end
    step(1);
    total++;
    if (dut.u_MyCPU.pc !== 32'd4) $display("FAIL first_pc: got %h want %h", dut.u_MyCPU.pc, 32'd4);
    else passed++;
    total++;
    if (dut.u_MyCPU.u_regs.regs[1] !== 32'hFFFFFFFF) $display("FAIL first_x1: got %h want ffffffff", dut.u_MyCPU.u_regs.regs[1]);
    else passed++;
    step(3);
    exp = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut.u_MyCPU.u_regs.regs[i] !== exp[i]) $display("FAIL alu_x%0d: got %h want %h", i, dut.u_MyCPU.u_regs.regs[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_store_ram();
    hold_and_clear();
    put(0, 32'h100002B7);
    put(1, 32'h00100313);
    put(2, 32'h0062A823);
    dut.u_ram._ram[4] = 32'd0;
    release_rst();
    step(2);
    total++;
    if (dut.u_ram._ram[4] !== 32'd0) $display("FAIL ram_early: got %h want 0", dut.u_ram._ram[4]);
    else passed++;
    step(1);
    total++;
    if (dut.u_ram._ram[4] !== 32'd1) $display("FAIL ram_sw: got %h want 1", dut.u_ram._ram[4]);
    else passed++;
  endtask

  task automatic test_loads_stores();
    logic [31:0] exp [3:12];
    hold_and_clear();
    put(0, 32'h800080B7);
    put(1, 32'h0F008093);
    put(2, 32'h10000113);
    put(3, 32'h00112023);
    put(4, 32'h00010183);
    put(5, 32'h00014203);
    put(6, 32'h00011283);
    put(7, 32'h00015303);
    put(8, 32'h00211383);
    put(9, 32'h00215403);
    put(10, 32'h05A00493);
    put(11, 32'h009100A3);
    put(12, 32'h00110503);
    put(13, 32'h00314583);
    put(14, 32'h00310603);
    release_rst();
    step(15);
    exp = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0, 32'hFFFF8000,
            32'h00008000, 32'h0000005A, 32'h0000005A, 32'h00000080, 32'hFFFFFF80};
    for (int i = 3; i <= 12; i++) begin
      total++;
      if (dut.u_MyCPU.u_regs.regs[i] !== exp[i]) $display("FAIL load_x%0d: got %h want %h", i, dut.u_MyCPU.u_regs.regs[i], exp[i]);
      else passed++;
    end
    total++;
    if (dut.u_rom._rom[64] !== 32'h80005AF0) $display("FAIL rom_sb: got %h want 80005af0", dut.u_rom._rom[64]);
    else passed++;
  endtask

  task automatic test_branch_jump();
    hold_and_clear();
    put(0, 32'hFFF00093);
    put(1, 32'h00100113);
    put(2, 32'h0020C463);
    put(3, 32'h00100513);
    put(4, 32'h0020E463);
    put(5, 32'h00200593);
    put(6, 32'h008000EF);
    put(7, 32'h00300613);
    put(8, 32'h00308067);
    release_rst();
    step(3);
    total++;
    if (dut.u_MyCPU.pc !== 32'd16) $display("FAIL blt_taken: got %h want %h", dut.u_MyCPU.pc, 32'd16);
    else passed++;
    step(1);
    total++;
    if (dut.u_MyCPU.pc !== 32'd20) $display("FAIL bltu_not_taken: got %h want %h", dut.u_MyCPU.pc, 32'd20);
    else passed++;
    step(2);
    total++;
    if (dut.u_MyCPU.pc !== 32'd32) $display("FAIL jal_pc: got %h want %h", dut.u_MyCPU.pc, 32'd32);
    else passed++;
    total++;
    if (dut.u_MyCPU.u_regs.regs[1] !== 32'd28) $display("FAIL jal_link: got %h want %h", dut.u_MyCPU.u_regs.regs[1], 32'd28);
    else passed++;
    step(1);
    total++;
    if (dut.u_MyCPU.pc !== 32'd30) $display("FAIL jalr_pc: got %h want %h", dut.u_MyCPU.pc, 32'd30);
    else passed++;
    total++;
    if (dut.u_MyCPU.u_regs.regs[10] !== 32'd0 || dut.u_MyCPU.u_regs.regs[12] !== 32'd0)
      $display("FAIL skipped_writes: got x10=%h x12=%h want 0", dut.u_MyCPU.u_regs.regs[10], dut.u_MyCPU.u_regs.regs[12]);
    else passed++;
    total++;
    if (dut.u_MyCPU.u_regs.regs[11] !== 32'd2) $display("FAIL fallthrough_x11: got %h want 2", dut.u_MyCPU.u_regs.regs[11]);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    hold_and_clear();
    put(0, 32'h100002B7);
    put(1, 32'h00100313);
    put(2, 32'h0062A823);
    dut.u_ram._ram[4] = 32'h55;
    release_rst();
    step(2);
    total++;
    if (dut.u_MyCPU.pc !== 32'd8) $display("FAIL mid_pc_before: got %h want %h", dut.u_MyCPU.pc, 32'd8);
    else passed++;
    @(negedge clk);
    rst = 1;
    step(1);
    total++;
    if (dut.u_MyCPU.pc !== 32'd0) $display("FAIL mid_pc: got %h want 0", dut.u_MyCPU.pc);
    else passed++;
    total++;
    if (dut.u_MyCPU.u_regs.regs[5] !== 32'd0 || dut.u_MyCPU.u_regs.regs[6] !== 32'd0)
      $display("FAIL mid_regs: got x5=%h x6=%h want 0", dut.u_MyCPU.u_regs.regs[5], dut.u_MyCPU.u_regs.regs[6]);
    else passed++;
    total++;
    if (dut.u_ram._ram[4] !== 32'h55) $display("FAIL mid_no_store: got %h want 55", dut.u_ram._ram[4]);
    else passed++;
    total++;
    if (dut.u_rom._rom[0] !== 32'h100002B7) $display("FAIL mid_rom_kept: got %h want 100002b7", dut.u_rom._rom[0]);
    else passed++;
    @(negedge clk);
    rst = 0;
    step(3);
    total++;
    if (dut.u_ram._ram[4] !== 32'd1) $display("FAIL rerun_store: got %h want 1", dut.u_ram._ram[4]);
    else passed++;
  endtask

  initial begin
    test_reset_and_alu();
    test_store_ram();
    test_loads_stores();
    test_branch_jump();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
